accelshark_psg_tdm_tx: RTL and testbench
========================================

ACCELSHARK_PSG_TDM_TX -- requirements
Module: accelshark_psg_tdm_tx

Interface
REQ-001 Parameter WIDTH, default 16, sample bits per channel (8..32).
REQ-002 Parameter SLOT_BITS, default 16, bit clocks per channel slot (WIDTH..64).
REQ-003 Parameter CHANNELS, default 2, slots per frame (2..8).
REQ-004 Ports SHALL be:
- `sclk  in  1` — bit clock, sole clock.
- `rst_n  in  1` — reset: asynchronous, active-low.
- `ena  in  1` — design enable.
- `fmt  in  1` — 0 = I2S (one-bit data delay), 1 = left-justified.
- `in_data  in  CHANNELS*WIDTH` — frame; channel c in bits [c*WIDTH +: WIDTH].
- `in_valid  in  1` — frame offered.
- `in_ready  out  1` — holding buffer empty.
- `ws  out  1` — word select / frame sync.
- `sdata  out  1` — serial data.
- `frame_start  out  1` — one-cycle pulse at frame wrap.
- `underrun  out  1` — one-cycle pulse when a wrap finds no frame.

Function
REQ-005 All state SHALL update on posedge sclk only.
REQ-006 Bit counter cnt SHALL count 0..CHANNELS*SLOT_BITS-1, increment each enabled cycle, and wrap to 0.
REQ-007 Slot s = cnt / SLOT_BITS; position p = cnt % SLOT_BITS.
REQ-008 ws SHALL be 0 while s == 0 and 1 for all other slots, in both formats (CHANNELS = 2 gives standard I2S left/right).
REQ-009 Left-justified bit L(cnt) SHALL be:
- p < WIDTH: shadow channel s, bit WIDTH-1-p (MSB first);
- otherwise: 0 padding.
REQ-010 With fmt_r = 1, sdata SHALL equal L(cnt) in the same cycle.
REQ-011 With fmt_r = 0, sdata SHALL equal the L value of the previous enabled cycle, so the MSB follows each ws edge by one bit and frame N's last bit appears at cnt = 0 of frame N+1.
REQ-012 fmt SHALL be sampled into fmt_r only on the wrap edge; mid-frame changes have no effect until the next frame.
REQ-013 A transfer SHALL occur when in_valid && in_ready at a posedge: in_data is copied to the holding buffer and hold_full is set.
REQ-014 in_ready SHALL be !hold_full, registered.
REQ-015 On the wrap edge (cnt FRAME-1 -> 0), the shadow register SHALL load as follows:
- hold_full = 1: shadow <= holding buffer, hold_full cleared;
- hold_full = 0: shadow <= all zeros and underrun pulses.
REQ-016 A transfer and a wrap on the same edge SHALL evaluate hold_full as it was before the edge; the offered frame lands in hold, with no bypass into the shadow.
REQ-017 frame_start SHALL be 1 for exactly the cycle in which cnt == 0.
REQ-018 With ena = 0:
- cnt, shadow, hold, fmt_r and ws SHALL hold;
- sdata, frame_start and underrun SHALL read 0;
- in_ready SHALL read 0 and no transfer occurs.
REQ-019 Samples are two's complement; no sign extension into padding bits.

Reset
REQ-020 While rst_n is low, the following SHALL hold:
- cnt = 0, ws = 0, sdata = 0, fmt_r = 0;
- shadow = 0, hold_full = 0;
- frame_start = 0, underrun = 0.
REQ-021 The first cycle after reset release SHALL be cnt = 0 of a silent frame, with in_ready = 1 when ena = 1.
REQ-022 Reset asserted mid-frame SHALL discard both the holding and shadow frames immediately, with no partial-word completion.

Configuration
REQ-023 Macro ACCELSHARK_PSG_TDM_UNDERRUN_CNT_EN, when defined, SHALL add output underrun_cnt[7:0]:
- increments on each underrun pulse;
- saturates at 8'hFF;
- reset to 0.
REQ-024 Without the macro, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (CHANNELS = 2, WIDTH = 16, SLOT_BITS = 16, ena = 1 unless stated)
REQ-025 LJ frame:
- stimulus: fmt = 1, push L = 16'hA5C3, R = 16'h00FF before the first wrap;
- response: next frame cnt 0..15 gives sdata 1010010111000011 with ws = 0; cnt 16..31 gives 0000000011111111 with ws = 1.
REQ-026 I2S frame:
- stimulus: same data, fmt = 0;
- response: sequence shifted one cycle later (L MSB at cnt = 1); ws edges unchanged.
REQ-027 Underrun:
- stimulus: no push for 3 frames;
- response: sdata constant 0, underrun pulses 3 times at cnt = 0, in_ready stays 1; with macro, underrun_cnt = 3.
REQ-028 Backpressure and collision:
- stimulus: push F1, then hold in_valid with F2; offer F2 on the same edge as the wrap;
- response: in_ready = 0 until that wrap; F2 lands in hold and is emitted one frame after F1; no underrun.
REQ-029 Padding and enable (WIDTH = 12, SLOT_BITS = 16):
- stimulus: push 12'hFFF, 12'hFFF, then drop ena for 5 cycles mid-slot;
- response: bits p = 12..15 of each slot = 0; during the ena gap, sdata = 0 and cnt frozen; stream resumes at the frozen bit.
REQ-030 Reset mid-frame:
- stimulus: assert rst_n low at cnt = 20;
- response: all outputs reach reset values immediately; after release, cnt = 0 and the frame is silent.

Source files
------------

// File: rtl/accelshark_psg_tdm_tx.sv
// TDM / I2S serial transmitter: one-frame holding buffer feeding a shadow register that is
// serialised MSB-first per slot. Define ACCELSHARK_PSG_TDM_UNDERRUN_CNT_EN to add underrun_cnt.
module accelshark_psg_tdm_tx #(
  parameter int WIDTH     = 16,
  parameter int SLOT_BITS = 16,
  parameter int CHANNELS  = 2
) (
  input  logic                      sclk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      fmt,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      ws,
  output logic                      sdata,
  output logic                      frame_start,
  output logic                      underrun
`ifdef ACCELSHARK_PSG_TDM_UNDERRUN_CNT_EN
  ,
  output logic [7:0]                underrun_cnt
`endif
);

  localparam int PW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW = CHANNELS * WIDTH;
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [PW-1:0] POS_LAST  = PW'(SLOT_BITS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(CHANNELS - 1);

  // The bit counter is kept as (slot, position) so no divider is needed.
  logic [PW-1:0] pos_q, pos_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          fmt_q, fmt_d;
  logic          dly_q, dly_d;
  logic          urun_q, urun_d;
  logic          wrap, xfer, lj_bit;
  logic [IW-1:0] bit_idx;

  always_comb begin
    wrap    = (pos_q == POS_LAST) && (slot_q == SLOT_LAST);
    xfer    = ena && in_valid && !hold_full_q;
    bit_idx = '0;
    lj_bit  = 1'b0;
    if (int'(pos_q) < WIDTH) begin
      bit_idx = IW'(int'(slot_q) * WIDTH + WIDTH - 1 - int'(pos_q));
      lj_bit  = shadow_q[bit_idx];
    end

    pos_d       = pos_q;
    slot_d      = slot_q;
    shadow_d    = shadow_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    fmt_d       = fmt_q;
    dly_d       = dly_q;
    urun_d      = urun_q;

    if (ena) begin
      pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
      if (pos_q == POS_LAST) slot_d = wrap ? '0 : slot_q + 1'b1;
      // I2S output is the left-justified stream delayed by one enabled bit clock.
      dly_d  = lj_bit;
      urun_d = wrap && !hold_full_q;
      if (wrap) begin
        fmt_d    = fmt;
        shadow_d = hold_full_q ? hold_q : '0;
        if (hold_full_q) hold_full_d = 1'b0;
      end
      // A transfer only happens into an empty hold, so it never races the wrap's clear.
      if (xfer) begin
        hold_d      = in_data;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q       <= '0;
      slot_q      <= '0;
      shadow_q    <= '0;
      hold_full_q <= 1'b0;
      fmt_q       <= 1'b0;
      dly_q       <= 1'b0;
      urun_q      <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      slot_q      <= slot_d;
      shadow_q    <= shadow_d;
      hold_full_q <= hold_full_d;
      fmt_q       <= fmt_d;
      dly_q       <= dly_d;
      urun_q      <= urun_d;
    end
  end

  // Hold contents are meaningless while hold_full is clear, so they need no reset.
  always_ff @(posedge sclk) begin
    hold_q <= hold_d;
  end

  assign ws          = (slot_q != '0);
  assign sdata       = ena && (fmt_q ? lj_bit : dly_q);
  assign frame_start = ena && rst_n && (pos_q == '0) && (slot_q == '0);
  assign underrun    = ena && urun_q;
  assign in_ready    = ena && !hold_full_q;

`ifdef ACCELSHARK_PSG_TDM_UNDERRUN_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] ucnt_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= 8'd0;
    end else if (ena && wrap && !hold_full_q) begin
      ucnt_q <= sat_inc(ucnt_q);
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_accelshark_psg_tdm_tx.sv
// Directed bench for accelshark_psg_tdm_tx: frame vectors in both formats plus
// underrun, backpressure, padding/enable-gap and mid-frame reset sequences.
module tb_accelshark_psg_tdm_tx;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1, fmt = 1'b0, in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, ws, sdata, frame_start, underrun;

  logic        ena12 = 1'b0, fmt12 = 1'b0, in_valid12 = 1'b0;
  logic [23:0] in_data12 = '0;
  logic        in_ready12, ws12, sdata12, frame_start12, underrun12;
`ifdef ACCELSHARK_PSG_TDM_UNDERRUN_CNT_EN
  logic [7:0]  ucnt, ucnt12;
`endif

  int n_err = 0;
  int n_chk = 0;

  always #5 sclk = ~sclk;

  accelshark_psg_tdm_tx #(.WIDTH(16), .SLOT_BITS(16), .CHANNELS(2)) u_dut (
    .sclk(sclk), .rst_n(rst_n), .ena(ena), .fmt(fmt), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .ws(ws), .sdata(sdata),
    .frame_start(frame_start), .underrun(underrun)
`ifdef ACCELSHARK_PSG_TDM_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt)
`endif
  );

  accelshark_psg_tdm_tx #(.WIDTH(12), .SLOT_BITS(16), .CHANNELS(2)) u_dut12 (
    .sclk(sclk), .rst_n(rst_n), .ena(ena12), .fmt(fmt12), .in_data(in_data12),
    .in_valid(in_valid12), .in_ready(in_ready12), .ws(ws12), .sdata(sdata12),
    .frame_start(frame_start12), .underrun(underrun12)
`ifdef ACCELSHARK_PSG_TDM_UNDERRUN_CNT_EN
    , .underrun_cnt(ucnt12)
`endif
  );

  typedef struct {
    logic        fmt;
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] exp_bits;
    logic        exp_tail;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Ends on a negedge with cnt = 0 of a fresh silent frame.
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_valid12 = 1'b0;
    ena = 1'b1;
    repeat (3) @(negedge sclk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with cnt = 0; returns at the negedge of the next cnt = 0.
  // Word bit 31 holds cnt 0. in_valid is dropped after the cnt 0 edge.
  task automatic capture(input logic glitch, output logic [31:0] b, output logic [31:0] w,
                         output logic [31:0] r, output logic [31:0] f, output logic [31:0] u);
    b = '0; w = '0; r = '0; f = '0; u = '0;
    for (int i = 0; i < 32; i++) begin
      #1;
      b[31-i] = sdata;
      w[31-i] = ws;
      r[31-i] = in_ready;
      f[31-i] = frame_start;
      u[31-i] = underrun;
      if (i == 1) in_valid = 1'b0;
      if (glitch && (i == 2 || i == 20)) fmt = ~fmt;
      @(negedge sclk);
    end
  endtask

  initial begin
    logic [31:0] b, w, r, f, u;
    int bad, pulses, stray, ones, notrdy, gap_bad;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] b, w, r, f, u;
    int bad, pulses, stray, ones, notrdy, gap_bad;

    vecs[0] = '{1'b1, 16'hA5C3, 16'h00FF, 32'hA5C300FF, 1'b0};
    vecs[1] = '{1'b0, 16'hA5C3, 16'h00FF, 32'h52E1807F, 1'b1};
    vecs[2] = '{1'b1, 16'h8000, 16'h0001, 32'h80000001, 1'b0};
    vecs[3] = '{1'b0, 16'h8000, 16'h0001, 32'h40000000, 1'b1};
    vecs[4] = '{1'b1, 16'h1234, 16'hABCD, 32'h1234ABCD, 1'b0};
    vecs[5] = '{1'b0, 16'h1234, 16'hABCD, 32'h091A55E6, 1'b1};
    vecs[6] = '{1'b1, 16'h0F0F, 16'hF0F0, 32'h0F0FF0F0, 1'b0};
    vecs[7] = '{1'b0, 16'h0F0F, 16'hF0F0, 32'h0787F878, 1'b0};

    // Reset state
    repeat (3) @(negedge sclk);
    #1;
    chk("rst_outputs", {28'd0, ws, sdata, frame_start, underrun}, 32'd0);
    chk("rst_outputs12", {29'd0, ws12, sdata12, underrun12}, 32'd0);
`ifdef ACCELSHARK_PSG_TDM_UNDERRUN_CNT_EN
    chk("rst_ucnt", {24'd0, ucnt}, 32'd0);
`endif
    @(negedge sclk);
    rst_n = 1'b1;
    #1;
    chk("release_frame_start", {31'd0, frame_start}, 32'd1);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven frames, with a mid-frame fmt glitch that must not take effect
    foreach (vecs[k]) begin
      do_reset();
      fmt = vecs[k].fmt;
      in_data = {vecs[k].r, vecs[k].l};
      in_valid = 1'b1;
      @(negedge sclk);
      in_valid = 1'b0;
      repeat (31) @(negedge sclk);
      capture(1'b1, b, w, r, f, u);
      #1;
      chk($sformatf("vec%0d_bits", k), b, vecs[k].exp_bits);
      chk($sformatf("vec%0d_ws", k), w, 32'h0000FFFF);
      chk($sformatf("vec%0d_frame_start", k), f, 32'h80000000);
      chk($sformatf("vec%0d_underrun", k), u, 32'h00000000);
      chk($sformatf("vec%0d_tail", k), {31'd0, sdata}, {31'd0, vecs[k].exp_tail});
    end

    // Underrun: four silent frames, three wraps with an empty hold
    do_reset();
    pulses = 0; stray = 0; ones = 0; notrdy = 0;
    for (int i = 0; i < 128; i++) begin
      #1;
      if (underrun) pulses++;
      if (underrun && !frame_start) stray++;
      if (sdata) ones++;
      if (!in_ready) notrdy++;
      @(negedge sclk);
    end
    chk("urun_pulses", pulses, 3);
    chk("urun_not_at_cnt0", stray, 0);
    chk("urun_sdata_ones", ones, 0);
    chk("urun_in_ready_low", notrdy, 0);
`ifdef ACCELSHARK_PSG_TDM_UNDERRUN_CNT_EN
    chk("urun_cnt", {24'd0, ucnt}, 32'd3);
`endif

    // Backpressure: F1 fills hold, F2 waits until the wrap frees it
    do_reset();
    fmt = 1'b1;
    in_data = {16'h8003, 16'hC001};
    in_valid = 1'b1;
    #1;
    chk("bp_ready_first", {31'd0, in_ready}, 32'd1);
    @(negedge sclk);
    in_data = {16'h0180, 16'h7E7E};
    bad = 0;
    for (int i = 1; i < 32; i++) begin
      #1;
      if (in_ready) bad++;
      @(negedge sclk);
    end
    chk("bp_ready_low_until_wrap", bad, 0);
    capture(1'b0, b, w, r, f, u);
    chk("bp_f1_bits", b, 32'hC0018003);
    chk("bp_f1_ready", r, 32'h80000000);
    chk("bp_f1_underrun", u, 32'h0);
    capture(1'b0, b, w, r, f, u);
    chk("bp_f2_bits", b, 32'h7E7E0180);
    chk("bp_f2_ready", r, 32'hFFFFFFFF);
    chk("bp_f2_underrun", u, 32'h0);
    #1;
    chk("bp_f3_underrun", {31'd0, underrun}, 32'd1);

    // Padding and enable gap on the 12-bit instance
    do_reset();
    ena12 = 1'b1;
    fmt12 = 1'b1;
    in_data12 = {12'hFFF, 12'hFFF};
    in_valid12 = 1'b1;
    @(negedge sclk);
    in_valid12 = 1'b0;
    repeat (31) @(negedge sclk);
    b = '0; w = '0; gap_bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (i == 6) begin
        ena12 = 1'b0;
        repeat (5) begin
          #1;
          if (sdata12 || in_ready12 || frame_start12 || underrun12 || ws12) gap_bad++;
          @(negedge sclk);
        end
        ena12 = 1'b1;
      end
      #1;
      b[31-i] = sdata12;
      w[31-i] = ws12;
      @(negedge sclk);
    end
    chk("pad_bits", b, 32'hFFF0FFF0);
    chk("pad_ws", w, 32'h0000FFFF);
    chk("pad_gap_outputs", gap_bad, 0);
    ena12 = 1'b0;

    // Reset mid-frame discards shadow and hold
    do_reset();
    fmt = 1'b1;
    in_data = {16'hFFFF, 16'hFFFF};
    in_valid = 1'b1;
    @(negedge sclk);
    in_valid = 1'b0;
    repeat (31) @(negedge sclk);
    in_valid = 1'b1;
    @(negedge sclk);
    in_valid = 1'b0;
    repeat (19) @(negedge sclk);
    #1;
    chk("mid_pre_reset", {30'd0, ws, sdata}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {28'd0, ws, sdata, frame_start, underrun}, 32'd0);
    @(negedge sclk);
    @(negedge sclk);
    rst_n = 1'b1;
    capture(1'b0, b, w, r, f, u);
    chk("mid_silent_bits", b, 32'h0);
    chk("mid_silent_frame_start", f, 32'h80000000);
    chk("mid_silent_underrun", u, 32'h0);
    capture(1'b0, b, w, r, f, u);
    chk("mid_hold_discarded_bits", b, 32'h0);
    chk("mid_hold_discarded_underrun", u, 32'h80000000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
